// File: rtl/captura_operandos.sv
// Operand-entry stage: loads A, B and the opcode from one switch bank, one debounced button press each.
// Build option: define ANTIRREBOTE_EN to include the debounce filter; otherwise the synchronised level is used directly.
module captura_operandos #(
   parameter int ancho         = 3,
   parameter int CICLOS_REBOTE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [ancho:0]   interruptores,
   input  logic             boton_n,
   output logic [ancho:0]   operandoA,
   output logic [ancho:0]   operandoB,
   output logic [3:0]       seleccion,
   output logic             valido,
   output logic [1:0]       estado
);

   // state     | meaning
   // CARGA_A   | next press loads operand A
   // CARGA_B   | next press loads operand B
   // CARGA_SEL | next press loads the opcode and raises valido
   // LISTO     | values coherent; next press drops valido and restarts
   typedef enum logic [1:0] {
      CARGA_A   = 2'b00,
      CARGA_B   = 2'b01,
      CARGA_SEL = 2'b10,
      LISTO     = 2'b11
   } estado_t;

   estado_t          estado_q, estado_d;
   logic [ancho:0]   opa_q, opa_d;
   logic [ancho:0]   opb_q, opb_d;
   logic [3:0]       sel_q, sel_d;
   logic             valido_q, valido_d;
   logic             sinc1_q, sinc2_q;
   logic             filt_q, filt_d;
   logic [1:0]       vista_q;
   logic             armado_q, armado_d;
   logic             pulso;
   logic [3:0]       sel_nueva;

   if (ancho >= 3) begin : g_sel_directa
      assign sel_nueva = interruptores[3:0];
   end else begin : g_sel_extendida
      assign sel_nueva = {{(3 - ancho){1'b0}}, interruptores};
   end

`ifdef ANTIRREBOTE_EN
   localparam int CW = $clog2(CICLOS_REBOTE) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_REBOTE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sinc2_q != filt_q) begin
         if (cnt_q == CNT_MAX) filt_d = sinc2_q;
         else                  cnt_d  = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
`else
   localparam int rebote_unused = CICLOS_REBOTE;
   assign filt_d = sinc2_q;
`endif

   // A button already held through reset must be released before it can capture:
   // arm only once a real synchronised sample shows the button released.
   assign armado_d = armado_q | (vista_q[1] & filt_q & sinc2_q);
   assign pulso    = armado_q & filt_q & ~filt_d;

   always_comb begin
      estado_d = estado_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      sel_d    = sel_q;
      valido_d = valido_q;
      if (pulso) begin
         unique case (estado_q)
            CARGA_A: begin
               opa_d    = interruptores;
               estado_d = CARGA_B;
            end
            CARGA_B: begin
               opb_d    = interruptores;
               estado_d = CARGA_SEL;
            end
            CARGA_SEL: begin
               sel_d    = sel_nueva;
               valido_d = 1'b1;
               estado_d = LISTO;
            end
            LISTO: begin
               valido_d = 1'b0;
               estado_d = CARGA_A;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sinc1_q  <= 1'b1;
         sinc2_q  <= 1'b1;
         filt_q   <= 1'b1;
         vista_q  <= 2'b00;
         armado_q <= 1'b0;
         estado_q <= CARGA_A;
         opa_q    <= '0;
         opb_q    <= '0;
         sel_q    <= '0;
         valido_q <= 1'b0;
      end else begin
         sinc1_q  <= boton_n;
         sinc2_q  <= sinc1_q;
         filt_q   <= filt_d;
         vista_q  <= {vista_q[0], 1'b1};
         armado_q <= armado_d;
         estado_q <= estado_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         sel_q    <= sel_d;
         valido_q <= valido_d;
      end
   end

   assign operandoA = opa_q;
   assign operandoB = opb_q;
   assign seleccion = sel_q;
   assign valido    = valido_q;
   assign estado    = estado_q;

endmodule
